// File: rtl/incr_share_arbiter.sv
// Round-robin arbiter time-sharing one external WIDTH-bit "+1" incrementer
// among NUM_REQ requesters, with a saturating overflow-event counter.
module incr_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 2,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_val,
  output logic [WIDTH-1:0]           inc_a,
  input  logic [WIDTH-1:0]           inc_sum,
  input  logic                       inc_stat,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic [WIDTH-1:0]           result,
  output logic                       ovf,
  output logic                       busy,
  output logic [CNT_W-1:0]           ovf_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [WIDTH-1:0]     inc_a_q, inc_a_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 pick_found_s;
  logic [PTR_W-1:0]     pick_idx_s;
  logic [PTR_W-1:0]     pick_next_s;
  logic [NUM_REQ-1:0]   pick_onehot_s;
  logic [WIDTH-1:0]     pick_val_s;
  int                   scan_idx_s;
  int                   next_idx_s;

  // Round-robin search: first set request at or above ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    scan_idx_s   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx_s = int'(ptr_q) + k;
      if (scan_idx_s >= NUM_REQ) begin
        scan_idx_s = scan_idx_s - NUM_REQ;
      end else begin
        scan_idx_s = scan_idx_s;
      end
      if (!pick_found_s && req[PTR_W'(scan_idx_s)]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = PTR_W'(scan_idx_s);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Decode the winner into a one-hot grant, its operand and the next pointer.
  always_comb begin
    pick_onehot_s = '0;
    pick_val_s    = '0;
    next_idx_s    = int'(pick_idx_s) + 1;
    if (next_idx_s >= NUM_REQ) begin
      next_idx_s = 0;
    end else begin
      next_idx_s = next_idx_s;
    end
    pick_next_s = PTR_W'(next_idx_s);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx_s == PTR_W'(i)) begin
        pick_onehot_s[i] = 1'b1;
        pick_val_s       = req_val[i*WIDTH +: WIDTH];
      end else begin
        pick_onehot_s[i] = 1'b0;
      end
    end
  end

  // Next-state and registered-output logic of the IDLE/EXEC/RESP sequence.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    done_d   = done_q;
    inc_a_d  = inc_a_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          state_d = EXEC;
          gnt_d   = pick_onehot_s;
          inc_a_d = pick_val_s;
          ptr_d   = pick_next_s;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        // The incrementer output is trusted as-is; no internal cross-check.
        result_d = inc_sum;
        ovf_d    = inc_stat;
        done_d   = gnt_q;
        if (inc_stat && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
        state_d = RESP;
      end
      RESP: begin
        gnt_d   = '0;
        done_d  = '0;
        inc_a_d = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        done_d  = '0;
        inc_a_d = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      inc_a_q  <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      inc_a_q  <= inc_a_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign inc_a   = inc_a_q;
  assign gnt     = gnt_q;
  assign done    = done_q;
  assign result  = result_q;
  assign ovf     = ovf_q;
  assign busy    = busy_q;
  assign ovf_cnt = cnt_q;

endmodule

// Invariant checker for incr_share_arbiter outputs; instantiated alongside the design.
module incr_share_arbiter_chk #(
  parameter int NUM_REQ = 4
) (
  input logic               clk,
  input logic               rst_n,
  input logic [NUM_REQ-1:0] gnt,
  input logic [NUM_REQ-1:0] done,
  input logic               busy
);

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_done_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(done));
  a_done_in_gnt: assert property (@(posedge clk) disable iff (!rst_n) ((done & ~gnt) == '0));
  // A grant is outstanding exactly while the block is out of IDLE.
  a_busy_gnt: assert property (@(posedge clk) disable iff (!rst_n) (busy == (gnt != '0)));
  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n) (done != '0) |=> (done == '0));

endmodule

// File: tb/tb_incr_share_arbiter.sv
// Bench for incr_share_arbiter: directed vector table, hand sequences and a
// randomized run against a round-robin reference model.
module tb_incr_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0;
  logic [7:0] req_val = 8'b0;
  logic [1:0] inc_a;
  logic [1:0] inc_sum;
  logic       inc_stat;
  logic [3:0] gnt;
  logic [3:0] done;
  logic [1:0] result;
  logic       ovf;
  logic       busy;
  logic [7:0] ovf_cnt;

  int n_vec = 0;
  int n_mis = 0;

  incr_share_arbiter #(.NUM_REQ(4), .WIDTH(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_val(req_val),
    .inc_a(inc_a), .inc_sum(inc_sum), .inc_stat(inc_stat),
    .gnt(gnt), .done(done), .result(result), .ovf(ovf),
    .busy(busy), .ovf_cnt(ovf_cnt)
  );

  incr_share_arbiter_chk #(.NUM_REQ(4)) chk (
    .clk(clk), .rst_n(rst_n), .gnt(gnt), .done(done), .busy(busy)
  );

  // Shared incrementer
  assign inc_sum  = inc_a + 2'd1;
  assign inc_stat = (inc_a == 2'b11);

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req = 4'b0;
    req_val = 8'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One full operation from IDLE; expected values supplied by the caller.
  task automatic do_op(input logic [3:0] r, input logic [7:0] v, input logic [3:0] eg,
                       input logic [1:0] er, input logic eo, input logic [7:0] ec,
                       input bit perturb, input string tag);
    logic [1:0] eop;
    eop = er - 2'd1;
    req = r;
    req_val = v;
    @(negedge clk);
    check({tag, " gnt"}, 32'(gnt), 32'(eg));
    check({tag, " busy exec"}, 32'(busy), 32'd1);
    check({tag, " inc_a"}, 32'(inc_a), 32'(eop));
    if (perturb) begin
      req = 4'($urandom);
      req_val = 8'($urandom);
    end
    @(negedge clk);
    check({tag, " done"}, 32'(done), 32'(eg));
    check({tag, " result"}, 32'(result), 32'(er));
    check({tag, " ovf"}, 32'(ovf), 32'(eo));
    check({tag, " ovf_cnt"}, 32'(ovf_cnt), 32'(ec));
    req = 4'b0;
    @(negedge clk);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " idle gnt"}, 32'(gnt | done), 32'd0);
    check({tag, " idle inc_a"}, 32'(inc_a), 32'd0);
    check({tag, " held result"}, 32'(result), 32'(er));
  endtask

  typedef struct {
    logic [3:0] r;
    logic [7:0] v;
    logic [3:0] eg;
    logic [1:0] er;
    logic       eo;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [7:0] tcnt;
    int         m_ptr;
    logic [7:0] m_cnt;
    logic [1:0] m_res;
    int         last;
    int         cyc;
    int         seen;

    // req_val packed as {r3, r2, r1, r0}; pointer starts at 0 after reset
    tbl[0] = '{4'b0001, 8'b00_00_00_01, 4'b0001, 2'b10, 1'b0};
    tbl[1] = '{4'b0100, 8'b00_11_00_00, 4'b0100, 2'b00, 1'b1};
    tbl[2] = '{4'b0101, 8'b00_00_00_10, 4'b0001, 2'b11, 1'b0};
    tbl[3] = '{4'b1010, 8'b11_00_00_00, 4'b0010, 2'b01, 1'b0};
    tbl[4] = '{4'b1010, 8'b11_00_01_00, 4'b1000, 2'b00, 1'b1};
    tbl[5] = '{4'b1111, 8'b11_10_01_00, 4'b0001, 2'b01, 1'b0};
    tbl[6] = '{4'b0001, 8'b00_00_00_11, 4'b0001, 2'b00, 1'b1};

    rst_n = 1'b0;
    #3;
    check("reset gnt", 32'(gnt), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset inc_a", 32'(inc_a), 32'd0);
    check("reset result/ovf", 32'({result, ovf}), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset ovf_cnt", 32'(ovf_cnt), 32'd0);
    apply_reset();

    tcnt = 8'd0;
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].eo) tcnt = tcnt + 8'd1;
      do_op(tbl[i].r, tbl[i].v, tbl[i].eg, tbl[i].er, tbl[i].eo, tcnt, 1'b0, $sformatf("tbl%0d", i));
    end

    // Requester 1 drops req and changes its operand while in flight
    do_op(4'b0010, 8'b00_00_10_00, 4'b0010, 2'b11, 1'b0, tcnt, 1'b1, "drop1");

    // Randomized run against the reference model
    apply_reset();
    m_ptr = 0;
    m_cnt = 8'd0;
    m_res = 2'b00;
    for (int it = 0; it < 150; it++) begin
      logic [3:0] r;
      logic [7:0] v;
      logic [1:0] op;
      logic [1:0] er;
      logic       eo;
      int         w;
      r = 4'($urandom_range(0, 15));
      v = 8'($urandom);
      if (r == 4'b0) begin
        req = r;
        req_val = v;
        @(negedge clk);
        check("rand noreq busy", 32'(busy), 32'd0);
        check("rand noreq gnt", 32'(gnt), 32'd0);
        check("rand noreq result", 32'(result), 32'(m_res));
      end else begin
        w = -1;
        for (int k = 0; k < 4; k++) begin
          if (w < 0 && r[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
        end
        op = v[2*w +: 2];
        er = 2'((int'(op) + 1) % 4);
        eo = (op == 2'b11);
        if (eo && m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
        m_ptr = (w + 1) % 4;
        m_res = er;
        do_op(r, v, 4'(1 << w), er, eo, m_cnt, bit'($urandom_range(0, 1)), "rand");
      end
    end

    // All requesters held high: strict rotation, done every 3 cycles
    apply_reset();
    req = 4'hF;
    req_val = 8'($urandom);
    last = 0;
    cyc = 0;
    seen = 0;
    while (seen < 8 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done != 4'b0) begin
        check("rr order", 32'(done), 32'(1 << (seen % 4)));
        if (seen > 0) check("rr done spacing", 32'(cyc - last), 32'd3);
        last = cyc;
        seen++;
      end
    end
    if (seen < 8) begin
      n_vec++;
      n_mis++;
      $display("FAIL rr timeout: got %0d done pulses, required 8", seen);
    end

    // Reset asserted while an operation is in EXEC
    req = 4'b0;
    repeat (4) @(negedge clk);
    req = 4'b0100;
    req_val = 8'b00_11_00_00;
    @(negedge clk);
    check("midrst pre gnt", 32'(gnt), 32'b0100);
    rst_n = 1'b0;
    #1;
    check("midrst gnt", 32'(gnt), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst inc_a", 32'(inc_a), 32'd0);
    check("midrst ovf_cnt", 32'(ovf_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'hF;
    @(negedge clk);
    check("midrst first gnt", 32'(gnt), 32'b0001);
    req = 4'b0;
    repeat (3) @(negedge clk);

    // Overflow counter saturation
    apply_reset();
    req = 4'b0001;
    req_val = 8'b0000_0011;
    seen = 0;
    cyc = 0;
    while (seen < 260 && cyc < 900) begin
      @(negedge clk);
      cyc++;
      if (done[0]) begin
        seen++;
        check("sat ovf_cnt", 32'(ovf_cnt), (seen > 255) ? 32'd255 : 32'(seen));
      end
    end
    if (seen < 260) begin
      n_vec++;
      n_mis++;
      $display("FAIL sat timeout: got %0d operations, required 260", seen);
    end
    req = 4'b0;
    repeat (4) @(negedge clk);
    check("sat hold", 32'(ovf_cnt), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/incr_share_arbiter.md
Name: incr_share_arbiter

Overview:
- Time-shares one combinational 2-bit "+1" incrementer (a in, sum/stat out) among NUM_REQ register requesters in the paper processor.
- Arbitrates round-robin, drives the incrementer operand, captures sum and carry-out, and returns the result with a one-cycle done pulse.
- Keeps a saturating count of overflow (wrap 3->0) events for status readout.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 2, operand/result width; must match the incrementer
CNT_W, 8, width of the overflow event counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester increment request, level
req_val  in  NUM_REQ*WIDTH  packed operands; requester i at bits [i*WIDTH +: WIDTH]
inc_a  out  WIDTH  operand to shared incrementer input a (registered)
inc_sum  in  WIDTH  incrementer sum output
inc_stat  in  1  incrementer carry-out (overflow)
gnt  out  NUM_REQ  one-hot grant; high while the requester's operation is in flight
done  out  NUM_REQ  one-hot, one-cycle pulse; result valid for that requester
result  out  WIDTH  captured sum; valid when any done bit is high, held otherwise
ovf  out  1  captured carry-out; qualified like result
busy  out  1  high in EXEC and RESP
ovf_cnt  out  CNT_W  saturating count of completed operations with ovf=1

Behaviour:
- Reset (async assert, sync release): state=IDLE; gnt=0, done=0, inc_a=0, result=0, ovf=0, busy=0, ovf_cnt=0, rr pointer=0 (requester 0 highest priority).
- States: IDLE, EXEC, RESP.
- IDLE: if req!=0, pick the first set bit searching upward from ptr, wrapping modulo NUM_REQ. On that edge: gnt=onehot(i), inc_a=req_val[i], ptr=(i+1) mod NUM_REQ, go EXEC. If req==0, stay in IDLE with outputs unchanged.
- EXEC (1 cycle): incrementer settles combinationally from inc_a. At the end of the cycle: result<=inc_sum, ovf<=inc_stat, done<=gnt, and ovf_cnt increments if inc_stat=1; go RESP.
- RESP (1 cycle): done pulse is visible. At the end of the cycle: gnt<=0, done<=0, inc_a<=0, go IDLE.
- Latency: req sampled high in IDLE at edge N -> gnt from N; done high in cycle N+2 -> N+3. Throughput is one operation per 3 cycles.
- Requester handshake:
  - Hold req and req_val stable until done is sampled.
  - Drop req on the same edge that samples done; a req still high in the following IDLE cycle counts as a new request.
- Operand is captured at grant. If req drops or req_val changes during EXEC/RESP, the operation still completes and done still pulses.
- Non-granted requests wait with no starvation. With all requesters continuously requesting, any requester is served within NUM_REQ operations.
- Arithmetic: result = (operand+1) mod 2^WIDTH; ovf=1 only for operand = 2^WIDTH-1. The block trusts inc_sum/inc_stat and does no internal check.
- ovf_cnt saturates at 2^CNT_W-1 and never wraps.
- result/ovf retain their last values after RESP.
- Reset mid-operation: immediate return to reset values. The pending done is lost and the requester must re-request.
- Invariants:
  - gnt and done are each one-hot or zero.
  - done is a subset of gnt.
  - busy == (state!=IDLE).

Test Plan:
- Reset, then req=4'b0001, req_val[1:0]=2'b01 -> gnt=0001 at edge 1; done=0001 with result=2'b10, ovf=0 in cycle 3; busy low from cycle 4.
- Single requester 2 with operand 2'b11 -> result=2'b00, ovf=1, ovf_cnt goes 0->1.
- req=4'b1111 held continuously, requesters dropping/re-raising req per the handshake -> grant order 0,1,2,3,0,…; done spacing is exactly 3 cycles.
- Requester 1 drops req and changes req_val during EXEC -> done[1] still pulses; result equals captured operand+1.
- Assert rst_n=0 during EXEC -> gnt, done, busy, inc_a cleared immediately; ovf_cnt=0; next grant goes to requester 0 first.
- 260 operations with operand 2'b11 (CNT_W=8) -> ovf_cnt saturates at 255 and stays there.
